// File: rtl/ecr_pkg.sv
// Shared definitions for the execution-condition register: state encoding and reset value.
// No logic; no latency.
// No flow control.
package ecr_pkg;

    typedef enum logic [1:0] {
        CORRECT   = 2'b00,
        PENDING   = 2'b01,
        INCORRECT = 2'b10,
        RSVD      = 2'b11
    } ecr_state_t;

    localparam logic [1:0] ECR_RESET_STATE = 2'b00;

endpackage

// File: rtl/ecr_age_arbiter.sv
// Picks the oldest requesting issue ID (wrap-aware), lowest port index on ties.
// Purely combinational, zero latency.
// No backpressure; grant is one-hot, or zero when nobody requests.
module ecr_age_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ID_WIDTH  = 8
) (
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_issue_id,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          grant_vld
);
    import ecr_pkg::*;

    // a is older than b when (a - b) is negative in ID_WIDTH-bit two's complement.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    logic [ID_WIDTH-1:0] best_id;
    logic [ID_WIDTH-1:0] cur_id;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        best_id   = '0;
        cur_id    = '0;
        // Strictly-older replacement keeps the lower index on equal IDs.
        for (int p = 0; p < NUM_PORTS; p++) begin
            cur_id = req_issue_id[p*ID_WIDTH +: ID_WIDTH];
            if (req[p] && (!grant_vld || is_older(cur_id, best_id))) begin
                grant     = '0;
                grant[p]  = 1'b1;
                grant_vld = 1'b1;
                best_id   = cur_id;
            end
        end
    end

endmodule

// File: rtl/execution_condition_register.sv
// Lock-arbitrated 2-bit execution-condition state; optional same-cycle write forward (ECR_WRITE_BYPASS_EN).
// Grant is combinational (0 cycles); writes and lock changes land at the next rising edge.
// Non-owners see grant=0 until the cycle after the owner pulses release_lock.
module execution_condition_register #(
    parameter int NUM_PORTS = 2,
    parameter int ID_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_read,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS-1:0]          release_lock,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_issue_id,
    input  logic [NUM_PORTS*2-1:0]        wdata,
    output logic [1:0]                    rdata,
    output logic [NUM_PORTS-1:0]          grant
);
    import ecr_pkg::*;

    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    ecr_state_t           state;
    logic                 lock_valid;
    logic [OW-1:0]        lock_owner;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] arb_grant;
    logic                 arb_grant_vld;
    logic                 any_grant;
    logic [OW-1:0]        gnt_idx;
    logic [1:0]           gnt_wdata;
    logic [1:0]           owner_wdata;

    assign req = req_read | req_write;

    ecr_age_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_arb (
        .req          (req),
        .req_issue_id (req_issue_id),
        .grant        (arb_grant),
        .grant_vld    (arb_grant_vld)
    );

    always_comb begin
        grant       = '0;
        gnt_idx     = '0;
        gnt_wdata   = '0;
        owner_wdata = '0;
        if (lock_valid) begin
            grant[lock_owner] = req[lock_owner];
        end else if (arb_grant_vld) begin
            grant = arb_grant;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                gnt_idx   = OW'(p);
                gnt_wdata = wdata[p*2 +: 2];
            end
            if (lock_owner == OW'(p)) begin
                owner_wdata = wdata[p*2 +: 2];
            end
        end
        any_grant = |grant;
    end

`ifdef ECR_WRITE_BYPASS_EN
    assign rdata = (lock_valid && req_write[lock_owner]) ? owner_wdata : state;
`else
    assign rdata = state;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ecr_state_t'(ECR_RESET_STATE);
            lock_valid <= 1'b0;
            lock_owner <= '0;
        end else begin
            if (any_grant && req_write[gnt_idx]) begin
                state <= ecr_state_t'(gnt_wdata);
            end
            // Owner release beats a simultaneous re-request from the same owner.
            if (lock_valid && release_lock[lock_owner]) begin
                lock_valid <= 1'b0;
            end else if (any_grant) begin
                lock_valid <= 1'b1;
                lock_owner <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_execution_condition_register.sv
// Table-driven bench for execution_condition_register with a queue-based scoreboard.
module tb_execution_condition_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_read, req_write, release_lock;
    logic [15:0] req_issue_id;
    logic [3:0]  wdata;
    logic [1:0]  rdata;
    logic [1:0]  grant;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        logic [1:0] rel;
        logic [7:0] id0;
        logic [7:0] id1;
        logic [1:0] wd0;
        logic [1:0] wd1;
        logic [1:0] exp_grant;
        logic [1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0] grant;
        logic [1:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    execution_condition_register #(.NUM_PORTS(2), .ID_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_read     (req_read),
        .req_write    (req_write),
        .release_lock (release_lock),
        .req_issue_id (req_issue_id),
        .wdata        (wdata),
        .rdata        (rdata),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] rel,
                       input logic [7:0] id0, input logic [7:0] id1,
                       input logic [1:0] wd0, input logic [1:0] wd1,
                       input logic [1:0] eg, input logic [1:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rel = rel; v.id0 = id0; v.id1 = id1;
        v.wd0 = wd0; v.wd1 = wd1; v.exp_grant = eg; v.exp_rdata = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] rel,
                         input logic [7:0] id0, input logic [7:0] id1,
                         input logic [1:0] wd0, input logic [1:0] wd1);
        req_read     = rd;
        req_write    = wr;
        release_lock = rel;
        req_issue_id = {id1, id0};
        wdata        = {wd1, wd0};
    endtask

    // Drive one cycle after the falling edge, queue its expectation, compare 2 ns later.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        drive(v.rd, v.wr, v.rel, v.id0, v.id1, v.wd0, v.wd1);
        e.grant = v.exp_grant;
        e.rdata = v.exp_rdata;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        check({tag, " grant"}, grant, e.grant);
        check({tag, " rdata"}, rdata, e.rdata);
    endtask

    logic [1:0] bypass_exp;

    initial begin
`ifdef ECR_WRITE_BYPASS_EN
        bypass_exp = 2'b10;
`else
        bypass_exp = 2'b01;
`endif
        //   rd     wr     rel    id0  id1  wd0    wd1    grant  rdata
        add(2'b00, 2'b00, 2'b11, 8'd0,   8'd0,  2'b00, 2'b00, 2'b00, 2'b00); // release while unlocked
        add(2'b00, 2'b01, 2'b00, 8'd10,  8'd0,  2'b10, 2'b00, 2'b01, 2'b00); // P0 write 10
        add(2'b00, 2'b00, 2'b00, 8'd10,  8'd0,  2'b00, 2'b00, 2'b00, 2'b10);
        add(2'b10, 2'b00, 2'b00, 8'd0,   8'd15, 2'b00, 2'b00, 2'b00, 2'b10); // P1 blocked
        add(2'b10, 2'b00, 2'b01, 8'd0,   8'd15, 2'b00, 2'b00, 2'b00, 2'b10); // release cycle still held
        add(2'b10, 2'b00, 2'b00, 8'd0,   8'd15, 2'b00, 2'b00, 2'b10, 2'b10); // P1 granted
        add(2'b00, 2'b00, 2'b10, 8'd0,   8'd0,  2'b00, 2'b00, 2'b00, 2'b10);
        add(2'b11, 2'b00, 2'b00, 8'd20,  8'd5,  2'b00, 2'b00, 2'b10, 2'b10); // older P1 wins
        add(2'b10, 2'b00, 2'b10, 8'd20,  8'd5,  2'b00, 2'b00, 2'b10, 2'b10); // release beats re-request
        add(2'b11, 2'b00, 2'b00, 8'd7,   8'd7,  2'b00, 2'b00, 2'b01, 2'b10); // tie -> P0
        add(2'b01, 2'b00, 2'b01, 8'd7,   8'd0,  2'b00, 2'b00, 2'b01, 2'b10);
        add(2'b10, 2'b01, 2'b00, 8'd250, 8'd3,  2'b01, 2'b00, 2'b01, 2'b10); // wrap: 250 older
        add(2'b10, 2'b00, 2'b00, 8'd250, 8'd3,  2'b00, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 2'b10, 8'd250, 8'd3,  2'b00, 2'b00, 2'b00, 2'b01); // non-owner release
        add(2'b10, 2'b00, 2'b00, 8'd250, 8'd3,  2'b00, 2'b00, 2'b00, 2'b01);
        add(2'b11, 2'b01, 2'b00, 8'd250, 8'd3,  2'b10, 2'b00, 2'b01, bypass_exp); // owner write
        add(2'b10, 2'b00, 2'b01, 8'd250, 8'd3,  2'b00, 2'b00, 2'b00, 2'b10);
        add(2'b10, 2'b00, 2'b00, 8'd0,   8'd3,  2'b00, 2'b00, 2'b10, 2'b10);
        add(2'b00, 2'b00, 2'b10, 8'd0,   8'd0,  2'b00, 2'b00, 2'b00, 2'b10);
        add(2'b00, 2'b01, 2'b00, 8'd1,   8'd0,  2'b11, 2'b00, 2'b01, 2'b10); // reserved code stored
        add(2'b00, 2'b00, 2'b01, 8'd1,   8'd0,  2'b00, 2'b00, 2'b00, 2'b11);

        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00);
        #7;
        check("reset grant", grant, 2'b00);
        check("reset rdata", rdata, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while P0 holds the lock must drop both lock and state at once.
        @(negedge clk);
        drive(2'b00, 2'b01, 2'b00, 8'd4, 8'd9, 2'b01, 2'b00);
        #2;
        check("pre-rst grant", grant, 2'b01);
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 8'd4, 8'd9, 2'b00, 2'b00);
        #2;
        check("locked P1 grant", grant, 2'b00);
        check("locked rdata", rdata, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-lock rst rdata", rdata, 2'b00);
        check("mid-lock rst grant", grant, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b10, 2'b00, 2'b00, 8'd0, 8'd9, 2'b00, 2'b00);
        #2;
        check("post-rst P1 grant", grant, 2'b10);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
